// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg -- shared states, reconfig addresses and M/C words for the PLL retune sequencer. Rev 1.0
`default_nettype none

package pll_cfg_pkg;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_IDLE = 3'd1,
    S_WR   = 3'd2,
    S_WAIT = 3'd3,
    S_LOCK = 3'd4
  } state_t;

  localparam logic [5:0]  c_ADDR_MODE  = 6'd0;
  localparam logic [5:0]  c_ADDR_START = 6'd2;
  localparam logic [5:0]  c_ADDR_M     = 6'd4;
  localparam logic [5:0]  c_ADDR_C     = 6'd5;
  localparam logic [5:0]  c_ADDR_K     = 6'd7;

  // M = 9 (odd duty), C0 = 16, C1 = 8 are shared by both standards; only K differs
  localparam logic [31:0] c_DATA_MODE  = 32'h0000_0001;
  localparam logic [31:0] c_DATA_M     = 32'h0002_0504;
  localparam logic [31:0] c_DATA_C0    = 32'h0000_0808;
  localparam logic [31:0] c_DATA_C1    = 32'h0004_0404;
  localparam logic [31:0] c_DATA_START = 32'h0000_0001;

  localparam logic [2:0]  c_LAST_STEP  = 3'd5;
  localparam int          c_TMO_W      = 21;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// sync2 -- two-flop synchroniser for a single asynchronous level, resets low. Rev 1.0
`default_nettype none

module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq -- retunes the PLL between PAL and NTSC through the reconfig mgmt port, holding the core in reset. Rev 1.0
`default_nettype none

module pll_cfg_seq
  import pll_cfg_pkg::*;
#(
  parameter int          LOCK_TIMEOUT = 2_000_000,
  parameter logic [31:0] K_PAL        = 32'd343828281,
  parameter logic [31:0] K_NTSC       = 32'd702812830
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ntsc,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  output logic        core_reset,
  output logic        busy,
  output logic        cfg_error,
  output logic        cur_ntsc
);

  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(LOCK_TIMEOUT - 1);

  state_t             r_state,    w_state_nxt;
  logic [2:0]         r_step,     w_step_nxt;
  logic               r_tgt,      w_tgt_nxt;
  logic [c_TMO_W-1:0] r_cnt,      w_cnt_nxt;
  logic               r_seen_low, w_seen_low_nxt;
  logic               r_wr,       w_wr_nxt;
  logic [5:0]         r_addr,     w_addr_nxt;
  logic [31:0]        r_data,     w_data_nxt;
  logic               r_core_rst, w_core_rst_nxt;
  logic               r_busy,     w_busy_nxt;
  logic               r_err,      w_err_nxt;
  logic               r_cur,      w_cur_nxt;

  logic               w_lock;
  logic [2:0]         w_dec_step;
  logic               w_dec_tgt;
  logic [5:0]         w_dec_addr;
  logic [31:0]        w_dec_data;

  sync2 u_lock_sync (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .i_d   (pll_locked),
    .o_q   (w_lock)
  );

  // In S_IDLE the first write is launched directly, so decode step 0 with the live request
  assign w_dec_step = (r_state == S_IDLE) ? 3'd0 : r_step;
  assign w_dec_tgt  = (r_state == S_IDLE) ? ntsc : r_tgt;

  always_comb begin
    w_dec_addr = 6'd0;
    w_dec_data = 32'd0;
    case (w_dec_step)
      3'd0: begin w_dec_addr = c_ADDR_MODE;  w_dec_data = c_DATA_MODE;  end
      3'd1: begin w_dec_addr = c_ADDR_M;     w_dec_data = c_DATA_M;     end
      3'd2: begin w_dec_addr = c_ADDR_K;     w_dec_data = w_dec_tgt ? K_NTSC : K_PAL; end
      3'd3: begin w_dec_addr = c_ADDR_C;     w_dec_data = c_DATA_C0;    end
      3'd4: begin w_dec_addr = c_ADDR_C;     w_dec_data = c_DATA_C1;    end
      3'd5: begin w_dec_addr = c_ADDR_START; w_dec_data = c_DATA_START; end
      default: begin w_dec_addr = 6'd0;      w_dec_data = 32'd0;        end
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_step_nxt     = r_step;
    w_tgt_nxt      = r_tgt;
    w_cnt_nxt      = r_cnt;
    w_seen_low_nxt = r_seen_low;
    w_wr_nxt       = r_wr;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_core_rst_nxt = r_core_rst;
    w_busy_nxt     = r_busy;
    w_err_nxt      = r_err;
    w_cur_nxt      = r_cur;

    case (r_state)
      S_BOOT: begin
        if (w_lock) begin
          w_state_nxt    = S_IDLE;
          w_core_rst_nxt = 1'b0;
        end
      end
      S_IDLE: begin
        if (ntsc != r_cur) begin
          w_tgt_nxt      = ntsc;
          w_busy_nxt     = 1'b1;
          w_core_rst_nxt = 1'b1;
          w_step_nxt     = 3'd0;
          w_wr_nxt       = 1'b1;
          w_addr_nxt     = w_dec_addr;
          w_data_nxt     = w_dec_data;
          w_state_nxt    = S_WR;
        end
      end
      S_WR: begin
        if (r_wr && !mgmt_waitrequest) begin
          w_wr_nxt   = 1'b0;
          w_step_nxt = r_step + 3'd1;
          if (r_step == c_LAST_STEP) begin
            w_cnt_nxt      = '0;
            w_seen_low_nxt = 1'b0;
            w_state_nxt    = S_LOCK;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_wr_nxt    = 1'b1;
        w_addr_nxt  = w_dec_addr;
        w_data_nxt  = w_dec_data;
        w_state_nxt = S_WR;
      end
      S_LOCK: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (!w_lock) begin
          w_seen_low_nxt = 1'b1;
        end
        // A stale high lock from the old configuration must not count as relock
        if (r_seen_low && w_lock) begin
          w_cur_nxt      = r_tgt;
          w_busy_nxt     = 1'b0;
          w_core_rst_nxt = 1'b0;
          w_err_nxt      = 1'b0;
          w_state_nxt    = S_IDLE;
        end else if (r_cnt == c_TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_cur_nxt   = r_tgt;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_BOOT;
      r_step     <= 3'd0;
      r_tgt      <= 1'b0;
      r_cnt      <= '0;
      r_seen_low <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= 6'd0;
      r_data     <= 32'd0;
      r_core_rst <= 1'b1;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_cur      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_tgt      <= w_tgt_nxt;
      r_cnt      <= w_cnt_nxt;
      r_seen_low <= w_seen_low_nxt;
      r_wr       <= w_wr_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_core_rst <= w_core_rst_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
      r_cur      <= w_cur_nxt;
    end
  end

  assign mgmt_address   = r_addr;
  assign mgmt_write     = r_wr;
  assign mgmt_writedata = r_data;
  assign core_reset     = r_core_rst;
  assign busy           = r_busy;
  assign cfg_error      = r_err;
  assign cur_ntsc       = r_cur;

endmodule

`default_nettype wire

// File: tb/tb_pll_cfg_seq.sv
// tb_pll_cfg_seq -- scoreboard bench for the PAL/NTSC PLL retune sequencer. Rev 1.0
`default_nettype none

module tb_pll_cfg_seq;

  localparam int          TMO        = 1000;
  localparam logic [31:0] K_PAL_EXP  = 32'd343828281;
  localparam logic [31:0] K_NTSC_EXP = 32'd702812830;

  logic        clk_sys          = 1'b0;
  logic        reset_n          = 1'b0;
  logic        ntsc             = 1'b0;
  logic        pll_locked       = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        core_reset;
  logic        busy;
  logic        cfg_error;
  logic        cur_ntsc;

  int          n_chk     = 0;
  int          n_fail    = 0;
  int          n_wr      = 0;
  int          cyc       = 0;
  int          t_start   = -1;
  int          stall_cnt = 0;
  bit          stall_mode = 1'b0;
  logic [37:0] sb_q[$];
  logic [37:0] held;
  logic [37:0] exp_wr;

  pll_cfg_seq #(
    .LOCK_TIMEOUT (TMO),
    .K_PAL        (K_PAL_EXP),
    .K_NTSC       (K_NTSC_EXP)
  ) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .ntsc             (ntsc),
    .pll_locked       (pll_locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .core_reset       (core_reset),
    .busy             (busy),
    .cfg_error        (cfg_error),
    .cur_ntsc         (cur_ntsc)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic push_seq(input bit tgt);
    sb_q.push_back({6'd0, 32'h0000_0001});
    sb_q.push_back({6'd4, 32'h0002_0504});
    sb_q.push_back({6'd7, tgt ? K_NTSC_EXP : K_PAL_EXP});
    sb_q.push_back({6'd5, 32'h0000_0808});
    sb_q.push_back({6'd5, 32'h0004_0404});
    sb_q.push_back({6'd2, 32'h0000_0001});
  endtask

  task automatic wait_sb();
    int b = 0;
    while (sb_q.size() != 0 && b < 400) begin
      tick();
      b++;
    end
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic lock_cycle(input int low);
    pll_locked = 1'b0;
    repeat (low) tick();
    pll_locked = 1'b1;
    tick();
    tick();
    check_eq("relock_hold_cr", 32'(core_reset), 32'd1);
    check_eq("relock_hold_busy", 32'(busy), 32'd1);
    tick();
    check_eq("relock_cr", 32'(core_reset), 32'd0);
    check_eq("relock_busy", 32'(busy), 32'd0);
    check_eq("relock_err", 32'(cfg_error), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_wr"},   32'(mgmt_write), 32'd0);
    check_eq({tag, "_addr"}, 32'(mgmt_address), 32'd0);
    check_eq({tag, "_data"}, mgmt_writedata, 32'd0);
    check_eq({tag, "_cr"},   32'(core_reset), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_err"},  32'(cfg_error), 32'd0);
    check_eq({tag, "_cur"},  32'(cur_ntsc), 32'd0);
  endtask

  // Bus monitor and waitrequest driver: decides the stall for the coming edge, then scores handshakes
  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset_n && mgmt_write) begin
        if (stall_mode && stall_cnt < 3) begin
          if (stall_cnt > 0) begin
            check_eq("stall_addr", 32'(mgmt_address), 32'(held[37:32]));
            check_eq("stall_data", mgmt_writedata, held[31:0]);
          end
          held = {mgmt_address, mgmt_writedata};
          stall_cnt++;
          mgmt_waitrequest = 1'b1;
        end else begin
          exp_wr = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
          check_eq("wr_addr", 32'(mgmt_address), 32'(exp_wr[37:32]));
          check_eq("wr_data", mgmt_writedata, exp_wr[31:0]);
          check_eq("wr_busy", 32'(busy), 32'd1);
          check_eq("wr_cr", 32'(core_reset), 32'd1);
          mgmt_waitrequest = 1'b0;
          stall_cnt = 0;
          n_wr++;
          if (mgmt_address == 6'd2) t_start = cyc;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cyc;
    int s;
    int base;
    int b;

    repeat (3) tick();
    check_reset_vals("rst");
    reset_n = 1'b1;
    repeat (10) tick();
    pll_locked = 1'b1;
    tick();
    tick();
    check_eq("boot_hold_cr", 32'(core_reset), 32'd1);
    tick();
    check_eq("boot_cr", 32'(core_reset), 32'd0);
    check_eq("boot_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check_eq("boot_nowr", 32'(n_wr), 32'd0);

    // PAL -> NTSC, no stalls
    push_seq(1'b1);
    ntsc    = 1'b1;
    req_cyc = cyc;
    tick();
    check_eq("req_lat_wr", 32'(mgmt_write), 32'd1);
    check_eq("req_busy", 32'(busy), 32'd1);
    check_eq("req_cr", 32'(core_reset), 32'd1);
    wait_sb();
    check_eq("start_lat", 32'(t_start - req_cyc), 32'd11);
    lock_cycle(100);
    check_eq("ntsc_cur", 32'(cur_ntsc), 32'd1);

    // NTSC -> PAL, every write stalled 3 cycles
    stall_mode = 1'b1;
    push_seq(1'b0);
    ntsc = 1'b0;
    wait_sb();
    stall_mode = 1'b0;
    check_eq("stall_nwr", 32'(n_wr), 32'd12);
    lock_cycle(30);
    check_eq("pal_cur", 32'(cur_ntsc), 32'd0);

    // PAL -> NTSC, lock never drops: timeout
    push_seq(1'b1);
    ntsc = 1'b1;
    wait_sb();
    s = t_start;
    while (cyc < s + TMO) tick();
    check_eq("tmo_early", 32'(cfg_error), 32'd0);
    tick();
    check_eq("tmo_err", 32'(cfg_error), 32'd1);
    check_eq("tmo_cr", 32'(core_reset), 32'd1);
    check_eq("tmo_busy", 32'(busy), 32'd0);
    check_eq("tmo_cur", 32'(cur_ntsc), 32'd1);
    repeat (5) tick();
    check_eq("tmo_sticky", 32'(cfg_error), 32'd1);
    check_eq("tmo_nwr", 32'(n_wr), 32'd18);

    // Retry back to PAL clears the error on lock
    push_seq(1'b0);
    ntsc = 1'b0;
    wait_sb();
    lock_cycle(20);
    check_eq("retry_cur", 32'(cur_ntsc), 32'd0);

    // Reset asserted while step 3 is on the bus
    push_seq(1'b1);
    ntsc = 1'b1;
    base = n_wr;
    b = 0;
    while (!(n_wr == base + 4 && mgmt_write && mgmt_address == 6'd5) && b < 100) begin
      tick();
      b++;
    end
    check_eq("step3_reached", 32'(n_wr - base), 32'd4);
    reset_n = 1'b0;
    ntsc    = 1'b0;
    #1;
    check_reset_vals("midrst");
    sb_q.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    tick();
    check_eq("reboot_hold_cr", 32'(core_reset), 32'd1);
    tick();
    check_eq("reboot_cr", 32'(core_reset), 32'd0);
    repeat (5) tick();
    check_eq("reboot_nowr", 32'(n_wr - base), 32'd4);
    check_eq("reboot_busy", 32'(busy), 32'd0);
    check_eq("reboot_cur", 32'(cur_ntsc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
